nw_traceback_decoder: RTL and testbench

//  Consumes the traceback coordinate stream the NW grid emits, ordered from (LENGTH-1,LENGTH-1)

---
 rtl/nw_pkg.sv | 44 ++++
 rtl/nw_step_classify.sv | 36 +++
 rtl/nw_traceback_decoder.sv | 160 ++++++++++++++++
 tb/tb_nw_traceback_decoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch grid and its traceback decoder.
package nw_pkg;

  localparam int unsigned CORD_LENGTH = 8;

  localparam logic [1:0] TOP_DIR    = 2'd1;
  localparam logic [1:0] LEFT_DIR   = 2'd2;
  localparam logic [1:0] CORNER_DIR = 2'd3;

  localparam int W_MATCH    = 1;
  localparam int W_INDEL    = -1;
  localparam int W_MISMATCH = -1;

  // Step codes reuse the grid's direction codes so the two sides agree on meaning.
  typedef enum logic [1:0] {
    STEP_BAD  = 2'd0,
    STEP_TOP  = TOP_DIR,
    STEP_LEFT = LEFT_DIR,
    STEP_DIAG = CORNER_DIR
  } step_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  typedef struct packed {
    logic [CORD_LENGTH-1:0] y;
    logic [CORD_LENGTH-1:0] x;
  } coord_t;

  function automatic coord_t coord_unpack(input logic [2*CORD_LENGTH-1:0] raw);
    return coord_t'(raw);
  endfunction

  function automatic logic [2*CORD_LENGTH-1:0] coord_pack(input logic [CORD_LENGTH-1:0] x,
                                                          input logic [CORD_LENGTH-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/nw_step_classify.sv
// Classifies one traceback move prev->cur as DIAG, TOP, LEFT or BAD.
module nw_step_classify
  import nw_pkg::*;
#(
  parameter int unsigned LENGTH = 10
) (
  input  coord_t i_prev,
  input  coord_t i_cur,
  output step_e  o_step
);

  localparam int unsigned EW = CORD_LENGTH + 1;
  localparam logic [EW-1:0] LEN = EW'(LENGTH);
  localparam logic [EW-1:0] ONE = EW'(1);

  // One extra bit so cur+1 never wraps back onto a small prev.
  logic [EW-1:0] w_px, w_py, w_cx, w_cy;
  assign w_px = {1'b0, i_prev.x};
  assign w_py = {1'b0, i_prev.y};
  assign w_cx = {1'b0, i_cur.x};
  assign w_cy = {1'b0, i_cur.y};

  always_comb begin
    o_step = STEP_BAD;
    if (w_cx < LEN && w_cy < LEN) begin
      if (w_cx + ONE == w_px && w_cy + ONE == w_py) begin
        o_step = STEP_DIAG;
      end else if (w_cx == w_px && w_cy + ONE == w_py) begin
        o_step = STEP_TOP;
      end else if (w_cx + ONE == w_px && w_cy == w_py) begin
        o_step = STEP_LEFT;
      end
    end
  end

endmodule

// File: rtl/nw_traceback_decoder.sv
// Turns the grid's traceback coordinate stream into aligned character pairs
// and re-derives the alignment score from them.
module nw_traceback_decoder
  import nw_pkg::*;
#(
  parameter int unsigned LENGTH   = 10,
  parameter int unsigned CWIDTH   = 2,
  parameter int unsigned SWIDTH   = 16,
  parameter int          MATCH    = W_MATCH,
  parameter int          INDEL    = W_INDEL,
  parameter int          MISMATCH = W_MISMATCH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LENGTH*CWIDTH-1:0] s1,
  input  logic [LENGTH*CWIDTH-1:0] s2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*CORD_LENGTH-1:0] in_coord,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CWIDTH-1:0]        out_c1,
  output logic                     out_gap1,
  output logic [CWIDTH-1:0]        out_c2,
  output logic                     out_gap2,
  output logic                     out_last,
  output logic                     done,
  output logic signed [SWIDTH-1:0] score,
  output logic                     error
);

  localparam int unsigned IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam coord_t CORNER = '{y: CORD_LENGTH'(LENGTH - 1), x: CORD_LENGTH'(LENGTH - 1)};

  state_e                           r_state;
  logic [LENGTH-1:0][CWIDTH-1:0]    r_s1, r_s2;
  coord_t                           r_prev;

  coord_t                           w_cur;
  logic                             w_free, w_accept;
  step_e                            w_step, w_step_eff;
  logic [CWIDTH-1:0]                w_ch1, w_ch2;
  logic signed [SWIDTH-1:0]         w_delta;

  assign w_cur    = coord_unpack(in_coord);
  assign w_free   = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: in_ready = w_free;
      ST_ERR:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  nw_step_classify #(.LENGTH(LENGTH)) u_classify (
    .i_prev (r_prev),
    .i_cur  (w_cur),
    .o_step (w_step)
  );

  // The final cell (0,0) is always emitted as a diagonal pair of the first chars.
  assign w_step_eff = (r_state == ST_FLUSH) ? STEP_DIAG : w_step;
  assign w_ch1      = r_s1[IW'(r_prev.y)];
  assign w_ch2      = r_s2[IW'(r_prev.x)];

  always_comb begin
    w_delta = SWIDTH'(INDEL);
    if (w_step_eff == STEP_DIAG) begin
      w_delta = (w_ch1 == w_ch2) ? SWIDTH'(MATCH) : SWIDTH'(MISMATCH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_s1      <= '0;
      r_s2      <= '0;
      r_prev    <= '0;
      out_valid <= 1'b0;
      out_c1    <= '0;
      out_gap1  <= 1'b0;
      out_c2    <= '0;
      out_gap2  <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      score     <= '0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_cur != CORNER) begin
              r_state <= ST_ERR;
              error   <= 1'b1;
            end else begin
              r_s1    <= s1;
              r_s2    <= s2;
              r_prev  <= w_cur;
              score   <= '0;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            if (w_step == STEP_BAD) begin
              r_state   <= ST_ERR;
              error     <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              out_c1    <= (w_step_eff == STEP_LEFT) ? '0 : w_ch1;
              out_gap1  <= (w_step_eff == STEP_LEFT);
              out_c2    <= (w_step_eff == STEP_TOP) ? '0 : w_ch2;
              out_gap2  <= (w_step_eff == STEP_TOP);
              out_last  <= 1'b0;
              score     <= score + w_delta;
              r_prev    <= w_cur;
              if (w_cur == '0) begin
                r_state <= ST_FLUSH;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (w_free) begin
            out_valid <= 1'b1;
            out_c1    <= w_ch1;
            out_gap1  <= 1'b0;
            out_c2    <= w_ch2;
            out_gap2  <= 1'b0;
            out_last  <= 1'b1;
            score     <= score + w_delta;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready) begin
            out_last <= 1'b0;
            done     <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          error     <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nw_traceback_decoder.sv
// Self-checking bench: LENGTH=4 and LENGTH=3 decoders against a path-walking reference model.
module tb_nw_traceback_decoder;

  typedef struct {int x; int y;} xy_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s1_4, s2_4;
  logic [5:0]  s1_3, s2_3;
  logic [15:0] coord;
  logic        iv, out_ready;
  int          sel;

  logic        ir4, ov4, g1_4, g2_4, last4, done4, err4;
  logic [1:0]  c1_4, c2_4;
  logic [15:0] sc4;
  logic        ir3, ov3, g1_3, g2_3, last3, done3, err3;
  logic [1:0]  c1_3, c2_3;
  logic [15:0] sc3;

  logic        iv4, iv3;
  assign iv4 = iv && (sel == 0);
  assign iv3 = iv && (sel == 1);

  initial forever #5 clk = ~clk;

  nw_traceback_decoder #(.LENGTH(4)) u4 (
    .clk(clk), .reset(reset), .s1(s1_4), .s2(s2_4), .in_valid(iv4), .in_ready(ir4),
    .in_coord(coord), .out_valid(ov4), .out_ready(out_ready), .out_c1(c1_4), .out_gap1(g1_4),
    .out_c2(c2_4), .out_gap2(g2_4), .out_last(last4), .done(done4), .score(sc4), .error(err4));

  nw_traceback_decoder #(.LENGTH(3)) u3 (
    .clk(clk), .reset(reset), .s1(s1_3), .s2(s2_3), .in_valid(iv3), .in_ready(ir3),
    .in_coord(coord), .out_valid(ov3), .out_ready(out_ready), .out_c1(c1_3), .out_gap1(g1_3),
    .out_c2(c2_3), .out_gap2(g2_3), .out_last(last3), .done(done3), .score(sc3), .error(err3));

  logic        o_ir, o_ov, o_done, o_err;
  logic [6:0]  o_fields;
  logic [15:0] o_score;

  always_comb begin
    if (sel == 0) begin
      o_ir = ir4; o_ov = ov4; o_done = done4; o_err = err4; o_score = sc4;
      o_fields = {c1_4, g1_4, c2_4, g2_4, last4};
    end else begin
      o_ir = ir3; o_ov = ov3; o_done = done3; o_err = err3; o_score = sc3;
      o_fields = {c1_3, g1_3, c2_3, g2_3, last3};
    end
  end

  int          n_asserts = 0;
  int          n_fail = 0;
  int          a1[4], a2[4];
  int          len;
  xy_t         path[$];
  logic [6:0]  exp_q[$];
  logic [15:0] exp_score;
  logic [15:0] errq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the path, one pair per step keyed by the cell being left.
  task automatic build_expected();
    int dx, dy, px, py;
    exp_q.delete();
    exp_score = 16'd0;
    for (int k = 0; k + 1 < path.size(); k++) begin
      px = path[k].x; py = path[k].y;
      dx = px - path[k+1].x; dy = py - path[k+1].y;
      if (dx == 1 && dy == 1) begin
        exp_q.push_back({2'(a1[py]), 1'b0, 2'(a2[px]), 1'b0, 1'b0});
        exp_score = exp_score + ((a1[py] == a2[px]) ? 16'd1 : 16'hFFFF);
      end else if (dx == 0) begin
        exp_q.push_back({2'(a1[py]), 1'b0, 2'd0, 1'b1, 1'b0});
        exp_score = exp_score + 16'hFFFF;
      end else begin
        exp_q.push_back({2'd0, 1'b1, 2'(a2[px]), 1'b0, 1'b0});
        exp_score = exp_score + 16'hFFFF;
      end
    end
    exp_q.push_back({2'(a1[0]), 1'b0, 2'(a2[0]), 1'b0, 1'b1});
    exp_score = exp_score + ((a1[0] == a2[0]) ? 16'd1 : 16'hFFFF);
  endtask

  task automatic random_case(input int l);
    int x, y, r;
    len = l;
    for (int i = 0; i < 4; i++) begin
      a1[i] = (i < l) ? int'($urandom_range(0, 3)) : 0;
      a2[i] = (i < l) ? int'($urandom_range(0, 3)) : 0;
    end
    path.delete();
    x = l - 1; y = l - 1;
    path.push_back('{x, y});
    while (x != 0 || y != 0) begin
      r = int'($urandom_range(0, 2));
      if (x == 0) r = 1;
      if (y == 0) r = 2;
      if (r != 1) x--;
      if (r != 2) y--;
      path.push_back('{x, y});
    end
  endtask

  task automatic drive_strings();
    for (int i = 0; i < 4; i++) begin
      s1_4[i*2 +: 2] = 2'(a1[i]);
      s2_4[i*2 +: 2] = 2'(a2[i]);
    end
    for (int i = 0; i < 3; i++) begin
      s1_3[i*2 +: 2] = 2'(a1[i]);
      s2_3[i*2 +: 2] = 2'(a2[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; iv = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(o_ov), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_error", 32'(o_err), 0);
    chk("rst_score", 32'(o_score), 0);
    chk("rst_fields", 32'(o_fields), 0);
    chk("rst_in_ready", 32'(o_ir), 1);
  endtask

  // mode 0: out_ready high; 1: random; 2: low for 5 cycles from cycle 4. abort>0 stops after that many pairs.
  task automatic run_stream(input int which, input int mode, input int abort);
    xy_t        cq[$];
    int         got, cyc;
    bit         fin, stalled;
    logic [6:0] held;
    sel = which;
    drive_strings();
    build_expected();
    cq = path;
    got = 0; fin = 0; stalled = 0; held = '0;
    for (cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 4 && cyc < 9);
      endcase
      if (cq.size() > 0) begin
        iv = 1'b1;
        coord = {8'(cq[0].y), 8'(cq[0].x)};
      end else begin
        iv = 1'b0;
      end
      #1;
      if (stalled) begin
        chk("bp_valid_held", 32'(o_ov), 1);
        chk("bp_fields_held", 32'(o_fields), 32'(held));
      end
      stalled = o_ov && !out_ready;
      held = o_fields;
      if (stalled) chk("bp_in_ready_low", 32'(o_ir), 0);
      if (o_done) begin
        chk("done_all_pairs", 32'(exp_q.size()), 0);
        chk("score", 32'(o_score), 32'(exp_score));
        chk("ready_at_done", 32'(o_ir), 1);
        fin = 1;
      end else if (o_ov && out_ready) begin
        if (exp_q.size() == 0) chk("extra_pair", 32'(o_fields), 32'h7F);
        else chk("pair", 32'(o_fields), 32'(exp_q.pop_front()));
        got++;
        if (abort > 0 && got == abort) fin = 1;
      end
      if (iv && o_ir && cq.size() > 0) void'(cq.pop_front());
    end
    iv = 1'b0;
    if (!fin) chk("stream_timeout", 0, 1);
    if (abort == 0) begin
      @(negedge clk); #1;
      chk("done_single_pulse", 32'(o_done), 0);
      chk("score_stable", 32'(o_score), 32'(exp_score));
    end
  endtask

  task automatic err_run(input int which);
    sel = which;
    out_ready = 1'b1;
    while (errq.size() > 0) begin
      @(negedge clk);
      iv = 1'b1;
      coord = errq.pop_front();
      #1;
      chk("err_no_valid", 32'(o_ov), 0);
      chk("err_in_ready", 32'(o_ir), 1);
    end
    repeat (4) begin
      @(negedge clk);
      coord = 16'($urandom);
      #1;
      chk("err_sticky", 32'(o_err), 1);
      chk("err_in_ready_drop", 32'(o_ir), 1);
      chk("err_no_valid_after", 32'(o_ov), 0);
    end
    iv = 1'b0;
  endtask

  initial begin
    sel = 0; iv = 1'b0; coord = '0; out_ready = 1'b1;
    s1_4 = '0; s2_4 = '0; s1_3 = '0; s2_3 = '0;
    do_reset();

    // ACGT vs ACGT straight diagonal
    a1 = '{0, 1, 2, 3}; a2 = '{0, 1, 2, 3}; len = 4;
    path = '{'{3, 3}, '{2, 2}, '{1, 1}, '{0, 0}};
    run_stream(0, 0, 0);
    chk("acgt_score", 32'(o_score), 32'd4);

    // LENGTH=3 ACG vs AGG mixed moves
    a1 = '{0, 1, 2, 0}; a2 = '{0, 2, 2, 0}; len = 3;
    path = '{'{2, 2}, '{2, 1}, '{1, 0}, '{0, 0}};
    run_stream(1, 0, 0);
    chk("acg_agg_score", 32'(o_score), 32'hFFFE);

    // five-cycle stall mid-stream
    random_case(4);
    run_stream(0, 2, 0);

    // malformed first coordinate, then a skipped diagonal
    do_reset();
    errq = '{{8'd3, 8'd2}};
    err_run(0);
    do_reset();
    errq = '{{8'd3, 8'd3}, {8'd1, 8'd1}};
    err_run(0);
    do_reset();
    errq = '{{8'd3, 8'd3}};
    err_run(1);
    do_reset();

    // reset after two pairs, then a clean full stream
    a1 = '{3, 0, 1, 2}; a2 = '{3, 0, 1, 2}; len = 4;
    path = '{'{3, 3}, '{2, 2}, '{1, 1}, '{0, 0}};
    run_stream(0, 0, 2);
    do_reset();
    random_case(4);
    run_stream(0, 1, 0);

    // back-to-back random streams on both sizes
    for (int n = 0; n < 6; n++) begin
      random_case(4);
      run_stream(0, n % 2, 0);
    end
    for (int n = 0; n < 4; n++) begin
      random_case(3);
      run_stream(1, 1 - (n % 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
